// File: rtl/output_drainer_m_axi_fifo_ths_if.sv
// Handshake bundle for output_drainer_m_axi_fifo_ths: write side, read side, status.
// slave is the FIFO's view, master is the view of the logic around it.
interface output_drainer_m_axi_fifo_ths_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  if_flush;
  logic                  if_full_n;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic [ADDR_WIDTH:0]   if_num_data_valid;
  logic                  if_almost_full;
  logic                  if_almost_empty;
  logic                  if_overflow;
  logic                  if_underflow;

  modport slave (
    input  if_flush, if_write, if_din, if_read,
    output if_full_n, if_empty_n, if_dout, if_num_data_valid,
    output if_almost_full, if_almost_empty, if_overflow, if_underflow
  );

  modport master (
    output if_flush, if_write, if_din, if_read,
    input  if_full_n, if_empty_n, if_dout, if_num_data_valid,
    input  if_almost_full, if_almost_empty, if_overflow, if_underflow
  );
endinterface

// File: rtl/output_drainer_m_axi_fifo_ths.sv
// First-word-fall-through FIFO for the output-drainer m_axi data paths.
// Capacity DEPTH = DEPTH-1 store entries plus the registered head word. Store is a shift
// register ("shiftreg") or a circular RAM ("distributed"/"block"); DEPTH==1 has no store.
// Define OUTPUT_DRAINER_FIFO_STATUS_EN to build the sticky overflow/underflow flags;
// otherwise both read as 0.
module output_drainer_m_axi_fifo_ths #(
  parameter string       MEM_STYLE     = "shiftreg",
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input logic                           clk,
  input logic                           reset,
  input logic                           clk_en,
  output_drainer_m_axi_fifo_ths_if.slave bus
);
  localparam int CW         = ADDR_WIDTH + 1;
  localparam int StoreDepth = (DEPTH > 1) ? int'(DEPTH) - 1 : 1;
  localparam logic [CW-1:0] CntOne    = CW'(1);
  localparam logic [CW-1:0] DepthM1   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] AfullLvl  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AemptyLvl = CW'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(StoreDepth - 1);

  logic [CW-1:0]         occ_q;
  logic                  full_n_q;
  logic                  dout_vld_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  push;
  logic                  rd;
  logic                  load;
  logic                  advance;
  logic [DATA_WIDTH-1:0] head;

  // Data may only move when enabled and not being flushed
  assign advance = clk_en & ~bus.if_flush;
  assign push    = bus.if_write & full_n_q;
  assign rd      = bus.if_read & dout_vld_q;

  if (DEPTH == 1) begin : g_direct
    // Single-entry FIFO: the output register is the whole storage
    assign load = push;
    assign head = bus.if_din;
  end else begin : g_store
    logic [CW-1:0] store_cnt;
    logic          store_ne;
    logic          pop_int;

    assign store_cnt = occ_q - {{(CW-1){1'b0}}, dout_vld_q};
    assign store_ne  = (store_cnt != '0);
    // Refill the head register whenever it is empty or being consumed
    assign pop_int   = store_ne & (bus.if_read | ~dout_vld_q);
    assign load      = pop_int;

    if (MEM_STYLE == "shiftreg") begin : g_shiftreg
      logic [ADDR_WIDTH-1:0] ptr_q;
      logic [DATA_WIDTH-1:0] sr_q [StoreDepth];

      // Read pointer follows the oldest word; it moves only on push-only or pop-only
      always_ff @(posedge clk) begin
        if (reset) begin
          ptr_q <= '0;
        end else if (clk_en) begin
          if (bus.if_flush) begin
            ptr_q <= '0;
          end else if (push && !pop_int) begin
            if (store_ne) ptr_q <= ptr_q + PtrOne;
          end else if (pop_int && !push) begin
            if (ptr_q != '0) ptr_q <= ptr_q - PtrOne;
          end
        end
      end

      // New words enter at index 0 and age towards higher indices
      always_ff @(posedge clk) begin
        if (advance && push) begin
          sr_q[0] <= bus.if_din;
          for (int i = 1; i < StoreDepth; i++) sr_q[i] <= sr_q[i-1];
        end
      end

      assign head = sr_q[ptr_q];
    end else begin : g_ram
      logic [ADDR_WIDTH-1:0] wr_ptr_q;
      logic [ADDR_WIDTH-1:0] rd_ptr_q;
      logic [DATA_WIDTH-1:0] mem [StoreDepth];

      // Circular pointers over the store entries
      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else if (clk_en) begin
          if (bus.if_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end else begin
            if (push)    wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrOne;
            if (pop_int) rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrOne;
          end
        end
      end

      // Plain write port; the head register acts as the synchronous read port
      always_ff @(posedge clk) begin
        if (advance && push) mem[wr_ptr_q] <= bus.if_din;
      end

      assign head = mem[rd_ptr_q];
    end
  end

  // Occupancy, full flag and head valid; reset beats clk_en, flush beats traffic
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      full_n_q   <= 1'b1;
      dout_vld_q <= 1'b0;
    end else if (clk_en) begin
      if (bus.if_flush) begin
        occ_q      <= '0;
        full_n_q   <= 1'b1;
        dout_vld_q <= 1'b0;
      end else begin
        if (push && !rd) begin
          occ_q <= occ_q + CntOne;
          if (occ_q == DepthM1) full_n_q <= 1'b0;
        end else if (rd && !push) begin
          occ_q    <= occ_q - CntOne;
          full_n_q <= 1'b1;
        end
        if (load) begin
          dout_vld_q <= 1'b1;
        end else if (rd) begin
          dout_vld_q <= 1'b0;
        end
      end
    end
  end

  // Head word register; contents are don't-care while invalid so it is never cleared
  always_ff @(posedge clk) begin
    if (!reset && advance && load) dout_q <= head;
  end

  assign bus.if_full_n         = full_n_q;
  assign bus.if_empty_n        = dout_vld_q;
  assign bus.if_dout           = dout_q;
  assign bus.if_num_data_valid = occ_q;
  assign bus.if_almost_full    = (occ_q >= AfullLvl);
  assign bus.if_almost_empty   = (occ_q <= AemptyLvl);

`ifdef OUTPUT_DRAINER_FIFO_STATUS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags; only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (advance) begin
      if (bus.if_write && !full_n_q)  overflow_q  <= 1'b1;
      if (bus.if_read && !dout_vld_q) underflow_q <= 1'b1;
    end
  end

  assign bus.if_overflow  = overflow_q;
  assign bus.if_underflow = underflow_q;
`else
  assign bus.if_overflow  = 1'b0;
  assign bus.if_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_output_drainer_m_axi_fifo_ths.sv
// Bench for output_drainer_m_axi_fifo_ths: three DEPTH=32 instances (one per storage style)
// share stimulus and are compared against a queue-based model; a DEPTH=1 instance runs a
// vector table.
module tb_output_drainer_m_axi_fifo_ths;
  localparam int MDepth = 32;
`ifdef OUTPUT_DRAINER_FIFO_STATUS_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        write, read, flush;
  logic [31:0] din;
  logic        w1, r1, f1;
  logic [31:0] d1;

  int checks = 0;
  int failures = 0;

  output_drainer_m_axi_fifo_ths_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_sr ();
  output_drainer_m_axi_fifo_ths_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_di ();
  output_drainer_m_axi_fifo_ths_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_bk ();
  output_drainer_m_axi_fifo_ths_if #(.DATA_WIDTH(32), .ADDR_WIDTH(1)) if_d1 ();

  assign if_sr.if_write = write; assign if_sr.if_read = read;
  assign if_sr.if_flush = flush; assign if_sr.if_din  = din;
  assign if_di.if_write = write; assign if_di.if_read = read;
  assign if_di.if_flush = flush; assign if_di.if_din  = din;
  assign if_bk.if_write = write; assign if_bk.if_read = read;
  assign if_bk.if_flush = flush; assign if_bk.if_din  = din;
  assign if_d1.if_write = w1;    assign if_d1.if_read = r1;
  assign if_d1.if_flush = f1;    assign if_d1.if_din  = d1;

  output_drainer_m_axi_fifo_ths #(
    .MEM_STYLE("shiftreg"), .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)
  ) u_sr (.clk(clk), .reset(reset), .clk_en(clk_en), .bus(if_sr));

  output_drainer_m_axi_fifo_ths #(
    .MEM_STYLE("distributed"), .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)
  ) u_di (.clk(clk), .reset(reset), .clk_en(clk_en), .bus(if_di));

  output_drainer_m_axi_fifo_ths #(
    .MEM_STYLE("block"), .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)
  ) u_bk (.clk(clk), .reset(reset), .clk_en(clk_en), .bus(if_bk));

  output_drainer_m_axi_fifo_ths #(
    .MEM_STYLE("shiftreg"), .DATA_WIDTH(32), .ADDR_WIDTH(1), .DEPTH(1),
    .AFULL_THRESH(1), .AEMPTY_THRESH(0)
  ) u_d1 (.clk(clk), .reset(reset), .clk_en(clk_en), .bus(if_d1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: all words held by the FIFO in order, plus "head register valid"
  logic [31:0] mq[$];
  bit          m_vld, m_ovf, m_udf;

  task automatic model_reset();
    mq.delete();
    m_vld = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_step(input logic w, input logic [31:0] d, input logic r,
                            input logic f, input logic en);
    int stored;
    bit acc_w, acc_r, refill;
    if (!en) return;
    if (f) begin
      mq.delete();
      m_vld = 0;
      return;
    end
    acc_w = w && (mq.size() < MDepth);
    acc_r = r && m_vld;
    if (w && !acc_w) m_ovf = 1;
    if (r && !m_vld) m_udf = 1;
    stored = mq.size() - int'(m_vld);
    refill = (stored > 0) && (r || !m_vld);
    if (acc_r) void'(mq.pop_front());
    if (acc_w) mq.push_back(d);
    m_vld = refill || (m_vld && !acc_r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic full_n, input logic empty_n,
                           input logic [31:0] dout, input logic [5:0] occ, input logic af,
                           input logic ae, input logic ovf, input logic udf);
    int n;
    n = mq.size();
    chk({tag, ".occ"}, occ, n);
    chk({tag, ".full_n"}, full_n, n < MDepth);
    chk({tag, ".empty_n"}, empty_n, m_vld);
    if (m_vld) chk({tag, ".dout"}, dout, mq[0]);
    chk({tag, ".afull"}, af, n >= MDepth - 2);
    chk({tag, ".aempty"}, ae, n <= 2);
    chk({tag, ".overflow"}, ovf, StatusEn & m_ovf);
    chk({tag, ".underflow"}, udf, StatusEn & m_udf);
  endtask

  task automatic check_all();
    check_dut("sr", if_sr.if_full_n, if_sr.if_empty_n, if_sr.if_dout, if_sr.if_num_data_valid,
              if_sr.if_almost_full, if_sr.if_almost_empty, if_sr.if_overflow,
              if_sr.if_underflow);
    check_dut("di", if_di.if_full_n, if_di.if_empty_n, if_di.if_dout, if_di.if_num_data_valid,
              if_di.if_almost_full, if_di.if_almost_empty, if_di.if_overflow,
              if_di.if_underflow);
    check_dut("bk", if_bk.if_full_n, if_bk.if_empty_n, if_bk.if_dout, if_bk.if_num_data_valid,
              if_bk.if_almost_full, if_bk.if_almost_empty, if_bk.if_overflow,
              if_bk.if_underflow);
  endtask

  // One clock of shared stimulus on the DEPTH=32 instances, checked after the edge
  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f,
                      input logic en);
    write = w; din = d; read = r; flush = f; clk_en = en;
    model_step(w, d, r, f, en);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic en);
    reset = 1'b1; write = 0; read = 0; flush = 0; din = '0;
    w1 = 0; r1 = 0; f1 = 0; d1 = '0; clk_en = en;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; clk_en = 1'b1;
    model_reset();
    check_all();
  endtask

  typedef struct {
    logic        w;
    logic [31:0] d;
    logic        r;
    logic        f;
    logic        e_empty_n;
    logic        e_full_n;
    logic [31:0] e_dout;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[11];
  int   gaps;
  bit   seen;

  initial begin
    // DEPTH=1 vectors: {write, din, read, flush, empty_n, full_n, dout, occ} after the edge
    vecs[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 2'd0};
    vecs[1]  = '{1'b1, 32'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5A, 2'd1};
    vecs[2]  = '{1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5A, 2'd1};
    vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 2'd0};
    vecs[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 2'd0};
    vecs[5]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33, 2'd1};
    vecs[6]  = '{1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 2'd0};
    vecs[7]  = '{1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 1'b0, 32'h66, 2'd1};
    vecs[8]  = '{1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 2'd0};
    vecs[9]  = '{1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12, 2'd1};
    vecs[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 2'd0};

    do_reset(1'b1);

    // DEPTH=1 table
    for (int i = 0; i < 11; i++) begin
      w1 = vecs[i].w; d1 = vecs[i].d; r1 = vecs[i].r; f1 = vecs[i].f;
      @(posedge clk);
      #1;
      chk($sformatf("d1[%0d].empty_n", i), if_d1.if_empty_n, vecs[i].e_empty_n);
      chk($sformatf("d1[%0d].full_n", i), if_d1.if_full_n, vecs[i].e_full_n);
      chk($sformatf("d1[%0d].occ", i), if_d1.if_num_data_valid, vecs[i].e_occ);
      if (vecs[i].e_empty_n) chk($sformatf("d1[%0d].dout", i), if_d1.if_dout, vecs[i].e_dout);
    end
    w1 = 0; r1 = 0; f1 = 0;

    // Three writes then three reads
    step(1, 32'h11, 0, 0, 1);
    step(1, 32'h22, 0, 0, 1);
    step(1, 32'h33, 0, 0, 1);
    chk("t1.empty_n", if_sr.if_empty_n, 1'b1);
    chk("t1.dout", if_bk.if_dout, 32'h11);
    chk("t1.occ", if_di.if_num_data_valid, 6'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
    chk("t1.drained", if_sr.if_empty_n, 1'b0);

    // Fill to capacity, overflow attempt, then drain
    for (int i = 0; i < MDepth; i++) begin
      step(1, 32'h100 + i, 0, 0, 1);
      if (i == 28) chk("fill.afull29", if_sr.if_almost_full, 1'b0);
      if (i == 29) chk("fill.afull30", if_sr.if_almost_full, 1'b1);
    end
    chk("fill.full_n", if_bk.if_full_n, 1'b0);
    step(1, 32'hDEAD, 0, 0, 1);
    chk("fill.overflow", if_sr.if_overflow, StatusEn);
    for (int i = 0; i < MDepth; i++) begin
      step(0, 0, 1, 0, 1);
      if (i == 0) chk("drain.full_n", if_di.if_full_n, 1'b1);
    end
    chk("drain.occ", if_sr.if_num_data_valid, 6'd0);

    // Flush at occ=10 with a concurrent write; overflow must survive
    for (int i = 0; i < 10; i++) step(1, 32'h200 + i, 0, 0, 1);
    step(1, 32'hBEEF, 0, 1, 1);
    chk("flush.occ", if_sr.if_num_data_valid, 6'd0);
    chk("flush.empty_n", if_bk.if_empty_n, 1'b0);
    chk("flush.full_n", if_di.if_full_n, 1'b1);
    chk("flush.overflow", if_bk.if_overflow, StatusEn);

    // Streaming: write and read every cycle
    gaps = 0; seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1, i, 1, 0, 1);
      if (seen && !if_sr.if_empty_n) gaps++;
      if (if_sr.if_empty_n) seen = 1;
    end
    chk("stream.gaps", gaps, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1);

    // Underflow from a fresh reset, then a clk_en freeze mid-stream
    do_reset(1'b1);
    step(0, 0, 1, 0, 1);
    chk("udf.flag", if_sr.if_underflow, StatusEn);
    for (int i = 0; i < 5; i++) step(1, 32'h300 + i, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, $urandom, 1, 0, 0);
    chk("freeze.occ", if_sr.if_num_data_valid, 6'd5);
    chk("freeze.dout", if_bk.if_dout, 32'h300);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);
    chk("freeze.drained", if_di.if_num_data_valid, 6'd0);

    // Randomized traffic with phases that favour filling or draining
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 300) % 2 == 0) ? 75 : 35;
      rp = ((i / 300) % 2 == 0) ? 35 : 75;
      step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
           $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 90);
    end

    // Reset must clear sticky flags even with clk_en low
    do_reset(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
